// File: rtl/regfile_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl_if
// Bundles every bus that regfile_access_ctrl touches apart from clk/reset:
//   - instruction input      : instr, instr_valid, instr_ready
//   - operand output         : op_a, op_b, op_instr, op_valid, op_ready
//   - writeback input        : wb_valid, wb_addr, wb_data, wb_ready
//   - register bank side     : ReadRegister1/2, WriteRegister, WriteData,
//                              RegWrite, ReadData1/2
// modport master : the access controller (drives bank addresses and strobes)
// modport slave  : everything around it (decode, execute, writeback, bank)
// -----------------------------------------------------------------------------
interface regfile_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [31:0]       op_instr;
    logic              op_valid;
    logic              op_ready;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;

    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        input  instr, instr_valid,
        output instr_ready,
        output op_a, op_b, op_instr, op_valid,
        input  op_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        input  ReadData1, ReadData2
    );

    modport slave (
        output instr, instr_valid,
        input  instr_ready,
        input  op_a, op_b, op_instr, op_valid,
        output op_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl
// Sole initiator towards a 32x32 register bank. Accepts decoded instructions,
// reads rs/rt from the bank and hands the operands to execute. Accepts
// writebacks into a one-entry pending buffer and drains it into the bank in a
// dedicated WRITE state, so a bank write never overlaps an operand capture.
// Pending and same-cycle writebacks are forwarded to operands; $zero reads 0.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : regfile_access_ctrl_if.master (instr / operand / writeback / bank)
// -----------------------------------------------------------------------------
module regfile_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_access_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_HOLD} state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;

    logic              r_op_valid;
    logic [31:0]       r_op_instr;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;

    logic              w_instr_ready;
    logic              w_wb_ready;
    logic              w_instr_acc;
    logic              w_wb_acc;
    logic              w_wb_buf;
    logic              w_op_acc;

    assign w_instr_acc = w_instr_ready && bus.instr_valid;
    assign w_wb_acc    = w_wb_ready && bus.wb_valid;
    // Writes to $zero are accepted but go nowhere.
    assign w_wb_buf    = w_wb_acc && (bus.wb_addr != '0);
    assign w_op_acc    = r_op_valid && bus.op_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (r_pend_valid)     w_state_next = S_WRITE;
                     else if (w_instr_acc) w_state_next = S_READ;
            S_WRITE: w_state_next = S_IDLE;
            S_READ:  w_state_next = S_HOLD;
            S_HOLD:  if (w_op_acc)         w_state_next = r_pend_valid ? S_WRITE : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Both readies are forced low while reset is asserted.
    always_comb begin
        w_instr_ready = 1'b0;
        w_wb_ready    = 1'b0;
        if (!reset) begin
            w_wb_ready    = !r_pend_valid;
            w_instr_ready = (r_state == S_IDLE) && !r_pend_valid;
        end
    end

    // ---------------- pending write buffer ----------------
    // A writeback can only be accepted while the buffer is empty, and the
    // buffer is only drained in WRITE (where it is full), so the two never
    // collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else if (w_wb_buf) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= bus.wb_addr;
            r_pend_data  <= bus.wb_data;
        end else if (r_state == S_WRITE) begin
            r_pend_valid <= 1'b0;
        end
    end

    // ---------------- bank write port ----------------
    // Loaded on entry to WRITE so the strobe is high exactly for that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_regwrite <= (w_state_next == S_WRITE);
            if (w_state_next == S_WRITE) begin
                r_write_reg  <= r_pend_addr;
                r_write_data <= r_pend_data;
            end
        end
    end

    // ---------------- operand handshake ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_valid <= 1'b0;
            r_op_instr <= '0;
        end else begin
            if (w_instr_acc)            r_op_instr <= bus.instr;
            if (r_state == S_READ)      r_op_valid <= 1'b1;
            else if (w_op_acc)          r_op_valid <= 1'b0;
        end
    end

    // ---------------- per-operand read path ----------------
    // gi = 0 handles rs / op_a / port 1, gi = 1 handles rt / op_b / port 2.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [ADDR_W-1:0] r_rd_addr;
            logic [DATA_W-1:0] r_operand;
            logic [DATA_W-1:0] w_bank_data;
            logic [DATA_W-1:0] w_operand;

            if (gi == 0) begin : g_port1
                assign w_bank_data = bus.ReadData1;
            end else begin : g_port2
                assign w_bank_data = bus.ReadData2;
            end

            // Newest value wins: same-cycle writeback is younger than the
            // pending entry, which is younger than the bank contents.
            always_comb begin
                w_operand = w_bank_data;
                if (r_rd_addr == '0)
                    w_operand = '0;
                else if (w_wb_buf && (bus.wb_addr == r_rd_addr))
                    w_operand = bus.wb_data;
                else if (r_pend_valid && (r_pend_addr == r_rd_addr))
                    w_operand = r_pend_data;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rd_addr <= '0;
                    r_operand <= '0;
                end else begin
                    if (w_instr_acc)       r_rd_addr <= bus.instr[25-5*gi -: ADDR_W];
                    if (r_state == S_READ) r_operand <= w_operand;
                end
            end
        end
    endgenerate

    assign bus.instr_ready   = w_instr_ready;
    assign bus.wb_ready      = w_wb_ready;
    assign bus.op_valid      = r_op_valid;
    assign bus.op_instr      = r_op_instr;
    assign bus.op_a          = g_opnd[0].r_operand;
    assign bus.op_b          = g_opnd[1].r_operand;
    assign bus.ReadRegister1 = g_opnd[0].r_rd_addr;
    assign bus.ReadRegister2 = g_opnd[1].r_rd_addr;
    assign bus.WriteRegister = r_write_reg;
    assign bus.WriteData     = r_write_data;
    assign bus.RegWrite      = r_regwrite;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_ctrl
// Directed bench. Stimulus pushes hand-computed operand results and bank
// writes into queues; two monitors pop and compare whenever the DUT hands off
// operands or strobes RegWrite. A behavioural 32x32 bank sits on the bank side.
// -----------------------------------------------------------------------------
module tb_regfile_access_ctrl;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] instr;
    } op_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;

    regfile_access_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_access_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    int  n_pulses = 0;
    op_t exp_ops[$];
    wr_t exp_wr[$];
    op_t mon_op;
    wr_t mon_wr;
    logic prev_rw = 1'b0;

    logic [31:0] mem [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: combinational read, write on the rising edge.
    // Reset reloads the preset contents; $0 deliberately holds garbage.
    assign bus.ReadData1 = mem[bus.ReadRegister1];
    assign bus.ReadData2 = mem[bus.ReadRegister2];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h0000_0BAD;
            mem[9]  <= 32'd7;
            mem[10] <= 32'd3;
        end else if (bus.RegWrite) begin
            mem[bus.WriteRegister] <= bus.WriteData;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [15:0] tag);
        return {6'h00, rs, rt, tag};
    endfunction

    // Operand monitor
    always @(negedge clk) begin
        if (!reset && bus.op_valid && bus.op_ready) begin
            if (exp_ops.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL op_unexpected: got instr 0x%08h expected none", bus.op_instr);
            end else begin
                mon_op = exp_ops.pop_front();
                check("op_a", bus.op_a, mon_op.a);
                check("op_b", bus.op_b, mon_op.b);
                check("op_instr", bus.op_instr, mon_op.instr);
                $display("op  instr=0x%08h a=0x%08h b=0x%08h", bus.op_instr, bus.op_a, bus.op_b);
            end
        end
    end

    // Bank write monitor
    always @(negedge clk) begin
        if (bus.RegWrite) begin
            n_pulses++;
            check("regwrite_one_cycle", {31'd0, prev_rw}, 32'd0);
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected: got $%0d=0x%08h expected none",
                         bus.WriteRegister, bus.WriteData);
            end else begin
                mon_wr = exp_wr.pop_front();
                check("wr_addr", {27'd0, bus.WriteRegister}, {27'd0, mon_wr.addr});
                check("wr_data", bus.WriteData, mon_wr.data);
                $display("wr  $%0d=0x%08h", bus.WriteRegister, bus.WriteData);
            end
        end
        prev_rw = bus.RegWrite;
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] ea, input logic [31:0] eb,
                         input bit expect_out);
        op_t e;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.instr_ready) break;
        end
        check("instr_ready_wait", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        if (expect_out) begin
            e.a = ea; e.b = eb; e.instr = ins;
            exp_ops.push_back(e);
        end
    endtask

    task automatic send_wb(input logic [4:0] addr, input logic [31:0] data);
        wr_t w;
        bus.wb_addr  = addr;
        bus.wb_data  = data;
        bus.wb_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.wb_ready) break;
        end
        check("wb_ready_wait", {31'd0, bus.wb_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.wb_valid = 1'b0;
        if (addr != 5'd0) begin
            w.addr = addr; w.data = data;
            exp_wr.push_back(w);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        wr_t w;
        reset           = 1'b1;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.op_ready    = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        check("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        check("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
        check("rst_wb_ready", {31'd0, bus.wb_ready}, 32'd0);
        check("rst_op_a", bus.op_a, 32'd0);
        reset = 1'b0;

        // ---- single writeback while idle ----
        send_wb(5'd8, 32'hDEAD_BEEF);
        check("wb_pending_ready", {31'd0, bus.wb_ready}, 32'd0);
        @(posedge clk); #1;
        check("wr8_strobe", {31'd0, bus.RegWrite}, 32'd1);
        check("wr8_addr", {27'd0, bus.WriteRegister}, 32'd8);
        check("wr8_data", bus.WriteData, 32'hDEAD_BEEF);
        check("wr8_ready_low", {31'd0, bus.wb_ready}, 32'd0);
        @(posedge clk); #1;
        check("wr8_strobe_off", {31'd0, bus.RegWrite}, 32'd0);
        check("wr8_ready_back", {31'd0, bus.wb_ready}, 32'd1);
        check("wr8_bank", mem[8], 32'hDEAD_BEEF);

        // ---- plain read: $9=7, $10=3 ----
        snap = n_pulses;
        bus.op_ready = 1'b1;
        issue(mk_instr(5'd9, 5'd10, 16'h0003), 32'd7, 32'd3, 1'b1);
        check("rd_valid_read_cycle", {31'd0, bus.op_valid}, 32'd0);
        @(posedge clk); #1;
        check("rd_valid_hold_cycle", {31'd0, bus.op_valid}, 32'd1);
        check("rd_op_a", bus.op_a, 32'd7);
        check("rd_op_b", bus.op_b, 32'd3);
        @(posedge clk); #1;
        check("rd_valid_cleared", {31'd0, bus.op_valid}, 32'd0);
        check("rd_no_regwrite", n_pulses, snap);

        // ---- same-cycle bypass: wb $9=0x55 during READ ----
        bus.op_ready = 1'b0;
        issue(mk_instr(5'd9, 5'd10, 16'h0004), 32'h55, 32'd3, 1'b1);
        bus.wb_addr = 5'd9; bus.wb_data = 32'h55; bus.wb_valid = 1'b1;
        w.addr = 5'd9; w.data = 32'h55; exp_wr.push_back(w);
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        check("byp_op_a", bus.op_a, 32'h55);
        repeat (3) @(posedge clk);
        #1;
        check("byp_bank_old", mem[9], 32'd7);
        check("byp_no_write_in_hold", n_pulses, snap);
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        check("byp_write_after_hold", {31'd0, bus.RegWrite}, 32'd1);
        @(posedge clk); #1;
        check("byp_bank_new", mem[9], 32'h55);

        // ---- pend bypass: wb $10=0x66 accepted with the instruction ----
        bus.wb_addr = 5'd10; bus.wb_data = 32'h66; bus.wb_valid = 1'b1;
        issue(mk_instr(5'd9, 5'd10, 16'h0005), 32'h55, 32'h66, 1'b1);
        bus.wb_valid = 1'b0;
        w.addr = 5'd10; w.data = 32'h66; exp_wr.push_back(w);
        repeat (4) @(posedge clk);
        #1;
        check("pend_bank_new", mem[10], 32'h66);

        // ---- $zero ----
        snap = n_pulses;
        send_wb(5'd0, 32'h0000_FFFF);
        check("zero_not_pending", {31'd0, bus.wb_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("zero_no_write", n_pulses, snap);
        issue(mk_instr(5'd0, 5'd0, 16'h0006), 32'd0, 32'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // ---- backpressure with a writeback held pending ----
        bus.op_ready = 1'b0;
        issue(mk_instr(5'd9, 5'd10, 16'h0007), 32'h55, 32'h66, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_op_a", bus.op_a, 32'h55);
            check("bp_op_b", bus.op_b, 32'h66);
            check("bp_op_instr", bus.op_instr, mk_instr(5'd9, 5'd10, 16'h0007));
            check("bp_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
            if (k == 1) begin
                bus.wb_addr = 5'd11; bus.wb_data = 32'h77; bus.wb_valid = 1'b1;
                w.addr = 5'd11; w.data = 32'h77; exp_wr.push_back(w);
            end
            if (k == 2) bus.wb_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("bp_still_no_write", {31'd0, bus.RegWrite}, 32'd0);
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_write_strobe", {31'd0, bus.RegWrite}, 32'd1);
        check("bp_write_addr", {27'd0, bus.WriteRegister}, 32'd11);
        check("bp_write_data", bus.WriteData, 32'h77);
        repeat (3) @(posedge clk);
        #1;

        // ---- reset mid-READ with $5=0x11 pending ----
        bus.wb_addr = 5'd5; bus.wb_data = 32'h11; bus.wb_valid = 1'b1;
        issue(mk_instr(5'd9, 5'd10, 16'h0008), 32'd0, 32'd0, 1'b0);
        bus.wb_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mr_op_a", bus.op_a, 32'd0);
        check("mr_op_b", bus.op_b, 32'd0);
        check("mr_op_instr", bus.op_instr, 32'd0);
        check("mr_op_valid", {31'd0, bus.op_valid}, 32'd0);
        check("mr_rdreg1", {27'd0, bus.ReadRegister1}, 32'd0);
        check("mr_rdreg2", {27'd0, bus.ReadRegister2}, 32'd0);
        check("mr_wrreg", {27'd0, bus.WriteRegister}, 32'd0);
        check("mr_wrdata", bus.WriteData, 32'd0);
        check("mr_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        check("mr_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
        check("mr_wb_ready", {31'd0, bus.wb_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        snap = n_pulses;
        repeat (6) @(posedge clk);
        #1;
        check("mr_no_write_after", n_pulses, snap);
        check("mr_bank5", mem[5], 32'd0);
        check("mr_idle", {31'd0, bus.instr_ready}, 32'd1);
        check("mr_op_valid_after", {31'd0, bus.op_valid}, 32'd0);

        // ---- everything expected was seen ----
        check("ops_drained", exp_ops.size(), 32'd0);
        check("writes_drained", exp_wr.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
